song_player: RTL and testbench

SONG_PLAYER -- requirements
Module: song_player

---
 rtl/song_player.sv | 152 +++++++++++++++
 tb/tb_song_player.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// song_player: steps through a song ROM and plays each entry as a square-wave note.
// Each ROM word holds a duration in beats [15:8] and a note number [7:0].
// Note number n maps to octave n/12 and semitone n%12. Note 0 and notes above 127 are rests.
module song_player #(
  parameter int unsigned BEAT_TICKS = 32'd12500000,
  parameter int unsigned GAP_TICKS  = 32'd250000,
  parameter int unsigned END_ADDR   = 32'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [9:0]  count,
  input  logic [15:0] song_data,
  output logic        tone,
  output logic [7:0]  cur_note,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, ADVANCE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  note;
  logic [31:0] total;
  logic [6:0]  semi;
  logic [3:0]  octave;
  logic [31:0] beat_cnt;
  logic [31:0] half_cnt;
  logic        sq;
  logic        rest;
  logic        play_last;
  logic        in_gap;
  logic        end_hit;
  logic [21:0] shifted;
  logic [31:0] half_period;

  // Half-period in clocks of the lowest octave, C through B.
  function automatic logic [21:0] base_half(input logic [3:0] s);
    case (s)
      4'd0:    base_half = 22'd3057805;
      4'd1:    base_half = 22'd2886182;
      4'd2:    base_half = 22'd2724196;
      4'd3:    base_half = 22'd2571338;
      4'd4:    base_half = 22'd2427002;
      4'd5:    base_half = 22'd2290784;
      4'd6:    base_half = 22'd2162211;
      4'd7:    base_half = 22'd2040840;
      4'd8:    base_half = 22'd1926297;
      4'd9:    base_half = 22'd1818182;
      4'd10:   base_half = 22'd1716136;
      default: base_half = 22'd1619815;
    endcase
  endfunction

  // semi holds the remainder once DECODE finishes, so it is below 12 in PLAY.
  assign rest        = (note == 8'd0) || note[7];
  assign shifted     = base_half(semi[3:0]) >> octave;
  assign half_period = (shifted == 22'd0) ? 32'd1 : {10'd0, shifted};
  assign play_last   = (beat_cnt == total - 32'd1);
  assign in_gap      = (beat_cnt >= total - GAP_TICKS);
  assign end_hit     = (count == 10'(END_ADDR));

  assign busy     = (state != IDLE);
  assign tone     = (state == PLAY) && !rest && sq && !in_gap;
  assign cur_note = ((state == PLAY) && !rest) ? note : 8'd0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = (song_data[15:8] == 8'd0) ? ADVANCE : DECODE;
      DECODE:  if (rest || semi < 7'd24) state_nxt = PLAY;
      PLAY:    if (play_last) state_nxt = ADVANCE;
      ADVANCE: state_nxt = end_hit ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Latch the current ROM entry. Its outputs are masked outside PLAY, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      note  <= song_data[7:0];
      total <= 32'(song_data[15:8]) * BEAT_TICKS;
    end
  end

  // Address, octave division, beat and half-period counters, and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 10'd0;
      semi     <= 7'd0;
      octave   <= 4'd0;
      beat_cnt <= 32'd0;
      half_cnt <= 32'd0;
      sq       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        count    <= 10'd0;
        beat_cnt <= 32'd0;
        half_cnt <= 32'd0;
        sq       <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) count <= 10'd0;
          FETCH: begin
            semi   <= song_data[6:0];
            octave <= 4'd0;
          end
          DECODE: begin
            if (!rest && semi >= 7'd12) begin
              semi   <= semi - 7'd12;
              octave <= octave + 4'd1;
            end
            beat_cnt <= 32'd0;
            half_cnt <= 32'd0;
            sq       <= 1'b0;
          end
          PLAY: begin
            beat_cnt <= play_last ? 32'd0 : beat_cnt + 32'd1;
            if (half_cnt == half_period - 32'd1) begin
              half_cnt <= 32'd0;
              sq       <= ~sq;
            end else begin
              half_cnt <= half_cnt + 32'd1;
            end
          end
          ADVANCE: begin
            if (end_hit) begin
              count <= 10'd0;
              done  <= 1'b1;
            end else begin
              count <= count + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Testbench for song_player. Random songs are scored against a reference model
// that works out each note's length, tone high-time and first rising edge.
`timescale 1ns/1ps
module tb_song_player;

  localparam int BEAT = 1000;
  localparam int GAP  = 100;
  localparam int LAST = 7;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [9:0]  count;
  logic [15:0] song_data;
  logic        tone;
  logic [7:0]  cur_note;
  logic        busy, done;

  logic        start2, abort2;
  logic [9:0]  count2;
  logic [15:0] song_data2;
  logic        tone2;
  logic [7:0]  cur_note2;
  logic        busy2, done2;

  logic [15:0] rom [0:1023];

  always #5 clk = ~clk;

  assign song_data  = rom[count];
  assign song_data2 = {8'h00, count2[7:0]};

  song_player #(.BEAT_TICKS(BEAT), .GAP_TICKS(GAP), .END_ADDR(LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .count(count),
    .song_data(song_data), .tone(tone), .cur_note(cur_note), .busy(busy), .done(done)
  );

  song_player #(.BEAT_TICKS(10), .GAP_TICKS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .count(count2),
    .song_data(song_data2), .tone(tone2), .cur_note(cur_note2), .busy(busy2), .done(done2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int note;
    int len;
    int hi;
    int first;
  } rec_t;

  rec_t note_q[$];
  int   song_q[$];

  int base_tab [12] = '{3057805, 2886182, 2724196, 2571338, 2427002, 2290784,
                        2162211, 2040840, 1926297, 1818182, 1716136, 1619815};

  function automatic int half_of(int n);
    int h;
    h = base_tab[n % 12] >> (n / 12);
    return (h == 0) ? 1 : h;
  endfunction

  // Reference model: the whole-song cycle count and one record per sounding note.
  task automatic model_song();
    int t, d, n, len, s, hp, hi;
    bit r;
    rec_t rec;
    t = 0;
    for (int a = 0; a <= LAST; a++) begin
      d = int'(rom[a][15:8]);
      n = int'(rom[a][7:0]);
      t += 1;
      if (d == 0) begin
        t += 1;
      end else begin
        r = (n == 0) || (n > 127);
        t += r ? 1 : ((n / 12 > 1) ? n / 12 : 1);
        len = d * BEAT;
        t += len + 1;
        if (!r) begin
          hp = half_of(n);
          s  = len - GAP;
          hi = 0;
          for (int k = 0; k < s; k++) if (((k / hp) % 2) == 1) hi++;
          rec.note  = n;
          rec.len   = len;
          rec.hi    = hi;
          rec.first = (hp < s) ? hp : -1;
          note_q.push_back(rec);
        end
      end
    end
    song_q.push_back(t);
  endtask

  task automatic rand_rom();
    int r;
    logic [7:0] d, n;
    for (int a = 0; a <= LAST; a++) begin
      d = 8'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 6)       n = 8'($urandom_range(108, 127));
      else if (r == 6) n = 8'd0;
      else if (r == 7) n = 8'($urandom_range(128, 255));
      else             n = 8'($urandom_range(1, 107));
      rom[a] = {d, n};
    end
  endtask

  // Monitor: samples 1ns after each rising edge and scores against the queues.
  int cyc = 0, c1 = 0, songs_done = 0;
  bit mon_en = 0;
  bit in_win = 0, prev_busy = 0;
  int w_note, w_len, w_hi, w_first;

  initial begin
    int e;
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!mon_en) begin
        in_win    = 0;
        prev_busy = busy;
      end else begin
        if (busy && !prev_busy) c1 = cyc;
        if (done) begin
          if (song_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = song_q.pop_front();
            check("song_cycles", cyc - c1, e);
          end
          check("count_at_done", count, 0);
          check("busy_at_done", busy, 0);
          songs_done++;
        end
        if (in_win) begin
          if (int'(cur_note) == w_note) begin
            w_len++;
            if (tone) begin
              w_hi++;
              if (w_first < 0) w_first = w_len - 1;
            end
          end else begin
            if (note_q.size() == 0) begin
              check("unexpected_note", w_note, -1);
            end else begin
              r = note_q.pop_front();
              check("note_value", w_note, r.note);
              check("note_len", w_len, r.len);
              check("tone_high_cycles", w_hi, r.hi);
              check("first_rise", w_first, r.first);
            end
            in_win = 0;
          end
        end
        if (!in_win && cur_note != 8'd0) begin
          in_win  = 1;
          w_note  = int'(cur_note);
          w_len   = 1;
          w_hi    = tone ? 1 : 0;
          w_first = tone ? 0 : -1;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic run_song(int poke);
    int target, w;
    model_song();
    mon_en = 1;
    target = songs_done + 1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start = 1;
      @(negedge clk) start = 0;
    end
    w = 0;
    while (songs_done < target && w < 60000) begin
      @(negedge clk);
      w++;
    end
    if (songs_done < target) begin
      check("song_timeout", 0, 1);
      song_q.delete();
    end
    check("notes_left", note_q.size(), 0);
    note_q.delete();
    @(negedge clk);
    mon_en = 0;
  endtask

  task automatic wait_note();
    int w;
    w = 0;
    while (cur_note == 8'd0 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (cur_note == 8'd0) check("note_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mx, seen;
    bit got, wrapped, sounded;
    rst = 1; start = 0; abort = 0; start2 = 0; abort2 = 0;
    for (int a = 0; a < 1024; a++) rom[a] = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_count", count, 0);
    check("reset_tone", tone, 0);
    check("reset_cur_note", cur_note, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Full 1024-entry address range, every entry skipped.
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    n = 1; mx = int'(count2); got = 0; wrapped = 0; sounded = 0;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (done2) got = 1;
      else begin
        if (int'(count2) > mx) mx = int'(count2);
        if (count2 == 10'd0 && mx != 0) wrapped = 1;
      end
      if (tone2 || cur_note2 != 8'd0) sounded = 1;
    end
    check("wrap_done_seen", got, 1);
    check("wrap_max_count", mx, 1023);
    check("wrap_done_cycle", n, 2049);
    check("wrap_count_after", count2, 0);
    check("wrap_no_early_wrap", wrapped, 0);
    check("wrap_silent", sounded, 0);
    @(negedge clk);
    check("wrap_done_width", done2, 0);
    check("wrap_busy_after", busy2, 0);

    // Fixed song: skipped entry, rests, sounding notes, zero entry.
    rom[0] = 16'h003C; rom[1] = 16'h0200; rom[2] = 16'h037F; rom[3] = 16'h0145;
    rom[4] = 16'h01C8; rom[5] = 16'h037D; rom[6] = 16'h0000; rom[7] = 16'h020C;
    run_song(0);

    // Random songs; the first takes a start pulse while busy.
    rand_rom();
    rom[0] = {8'd1, rom[0][7:0]};
    run_song(60);
    rand_rom();
    run_song(0);

    // Abort mid-note.
    rand_rom();
    rom[0] = 16'h0000; rom[1] = 16'h0178;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    wait_note();
    repeat ($urandom_range(5, 50)) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    check("start_while_busy_count", count, 1);
    check("playing_note", cur_note, 120);
    abort = 1;
    @(negedge clk) abort = 0;
    check("abort_busy", busy, 0);
    check("abort_tone", tone, 0);
    check("abort_count", count, 0);
    check("abort_cur_note", cur_note, 0);
    check("abort_done", done, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort_stays_idle", seen, 0);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    check("abort_beats_start", busy, 0);

    // Reset mid-note with start in the same cycle.
    rand_rom();
    rom[0] = 16'h0000; rom[1] = 16'h0178;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    wait_note();
    repeat ($urandom_range(5, 50)) @(negedge clk);
    rst = 1; start = 1;
    @(negedge clk);
    rst = 0; start = 0;
    check("rst_busy", busy, 0);
    check("rst_tone", tone, 0);
    check("rst_count", count, 0);
    check("rst_cur_note", cur_note, 0);
    check("rst_done", done, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    check("rst_stays_idle", seen, 0);

    // A later start plays from address 0.
    rand_rom();
    run_song(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
